obi_slave_arbiter: RTL and testbench
====================================

Name: obi_slave_arbiter

Overview:
Shares one OBI slave port between MASTERS requesters: JtagHost, CoreD and CoreI by default. It uses round-robin arbitration, holds the selected request stable until the slave grants it, and tracks up to MAX_OUTSTANDING accepted transactions. Each slave response is routed back to the master that issued the request. It sits between the OBI interconnect master ports and a shared slave such as ram, so instruction fetch, data access and debug access can be interleaved fairly.

Parameters:
MASTERS, 3, number of requesting master ports (2..8)
MAX_OUTSTANDING, 2, depth of response-routing FIFO (power of 2, 1..8)
IDX_W, $clog2(MASTERS), width of master index (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
master_req_i  in  MASTERS  per-master OBI request
master_gnt_o  out  MASTERS  per-master grant (one-hot or zero)
master_rvalid_o  out  MASTERS  per-master response valid (one-hot or zero)
master_we_i  in  MASTERS x 1  write enable
master_be_i  in  MASTERS x 4  byte enables
master_addr_i  in  MASTERS x 32  address
master_wdata_i  in  MASTERS x 32  write data
master_rdata_o  out  MASTERS x 32  read data, the same slave_rdata_i broadcast to all masters
slave_req_o  out  1  request to slave
slave_gnt_i  in  1  slave grant
slave_rvalid_i  in  1  slave response valid
slave_we_o / slave_be_o / slave_addr_o / slave_wdata_o  out  1/4/32/32  muxed from the selected master
slave_rdata_i  in  32  slave read data
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  accepted transactions not yet answered
err_o  out  1  sticky flag: rvalid received with no outstanding transaction

Behaviour:
- Reset values:
  - rr_ptr=0, FIFO empty, outstanding_o=0, err_o=0, lock=0.
  - All gnt/rvalid outputs 0.
  - slave_req_o=0.
- Selection (combinational):
  - If lock=1, the locked index is selected.
  - Otherwise, the first master with req=1 is selected, searching from rr_ptr upward and wrapping modulo MASTERS.
- slave_req_o is 1 when a master is selected and the FIFO is not full. Slave attribute outputs come from the selected master; they are 0 when nothing is selected.
- Grant:
  - master_gnt_o[sel] = slave_gnt_i & slave_req_o, in the same cycle (zero-latency pass-through).
  - An accept is that condition being true.
- Lock:
  - Set when slave_req_o=1 and slave_gnt_i=0; it holds the selected index.
  - Cleared on accept.
  - This keeps address, we, be and wdata stable as OBI requires, even if a higher-priority master asserts meanwhile.
- rr_ptr update: on accept, rr_ptr <= (sel+1) mod MASTERS. rr_ptr does not change without an accept.
- Response routing:
  - On accept, push sel into the FIFO.
  - On slave_rvalid_i, pop the head and set master_rvalid_o[head]=1 in the same cycle.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- Full FIFO: slave_req_o is forced to 0, so no grant can occur. lock remains as it was.
- Empty FIFO with slave_rvalid_i=1: no master_rvalid_o is asserted, err_o is set to 1 until reset, and the FIFO is unchanged.
- A master deasserting req before it is granted is a protocol violation. The arbiter releases the lock only if no master is selected.
- Reset mid-operation clears all outstanding tracking immediately. Responses in flight are not delivered.
- Throughput: one accept per cycle when the slave grants continuously and the FIFO is not full.

Decomposition:
- Shared package obi_pkg:
  - OBI_AW=32, OBI_DW=32, OBI_BEW=4.
  - Request struct (we, be, addr, wdata).
  - Response struct (rdata).
- Sub-module obi_id_fifo: synchronous FIFO of IDX_W-bit entries, depth MAX_OUTSTANDING. Ports push/pop/full/empty/head/count; async active-low reset.
- The arbiter top contains the rr_ptr, lock and mux logic.

Test Plan:
- Single master: CoreD reads 0x1000_0010, slave gnt=1 with rvalid one cycle later and rdata=0xDEADBEEF. Expected: gnt[1] in cycle 0, rvalid[1] in cycle 1, rdata 0xDEADBEEF, outstanding_o returns to 0.
- Round-robin: all three masters hold req with gnt always 1. Expected grant order 0,1,2,0,1,2; no master is granted twice in a row while others wait.
- Lock: master 2 requests with slave_gnt_i=0 for 3 cycles, and master 0 asserts req in cycle 1. Expected: slave_addr_o stays master 2's address, master 2 is granted first when gnt rises, then master 0.
- Full FIFO (MAX_OUTSTANDING=2): two accepts with no rvalid, then a third request. Expected: slave_req_o=0 and outstanding_o=2. One rvalid pops the head; the third request is accepted the following cycle.
- Simultaneous push and pop: accept master 1 in the same cycle as rvalid for master 0. Expected: rvalid[0]=1 and outstanding_o unchanged.
- Spurious response: slave_rvalid_i=1 with an empty FIFO. Expected: err_o=1 and sticky, all master_rvalid_o=0. Asserting rst_ni low mid-burst clears err_o, outstanding_o and rr_ptr immediately.

Source files
------------

// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - shared OBI widths, request/response structs and index helper
package obi_pkg;

  localparam int unsigned OBI_AW  = 32;
  localparam int unsigned OBI_DW  = 32;
  localparam int unsigned OBI_BEW = 4;

  typedef struct packed {
    logic               we;
    logic [OBI_BEW-1:0] be;
    logic [OBI_AW-1:0]  addr;
    logic [OBI_DW-1:0]  wdata;
  } obi_req_t;

  typedef struct packed {
    logic [OBI_DW-1:0] rdata;
  } obi_rsp_t;

  // Increment an index and wrap it to zero at n; works for non-power-of-2 n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// rtl/obi_id_fifo.sv - small FIFO of master indices awaiting a slave response
module obi_id_fifo
  import obi_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned ID_W  = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [ID_W-1:0]  id_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [ID_W-1:0]  head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0][ID_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Overflow and underflow requests are ignored so the pointers never corrupt.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for storage, pointers and occupancy; push+pop leaves count unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = id_i;
      wr_ptr_d        = PTR_W'(wrap_inc(32'(wr_ptr_q), DEPTH));
    end
    if (do_pop) begin
      rd_ptr_d = PTR_W'(wrap_inc(32'(rd_ptr_q), DEPTH));
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared immediately on reset so in-flight IDs are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/obi_slave_arbiter.sv
// rtl/obi_slave_arbiter.sv - round-robin arbiter sharing one OBI slave among masters
module obi_slave_arbiter
  import obi_pkg::*;
#(
  parameter  int unsigned MASTERS         = 3,
  parameter  int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned IDX_W           = $clog2(MASTERS),
  localparam int unsigned OCNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [MASTERS-1:0]                master_req_i,
  output logic [MASTERS-1:0]                master_gnt_o,
  output logic [MASTERS-1:0]                master_rvalid_o,
  input  logic [MASTERS-1:0]                master_we_i,
  input  logic [MASTERS-1:0][OBI_BEW-1:0]   master_be_i,
  input  logic [MASTERS-1:0][OBI_AW-1:0]    master_addr_i,
  input  logic [MASTERS-1:0][OBI_DW-1:0]    master_wdata_i,
  output logic [MASTERS-1:0][OBI_DW-1:0]    master_rdata_o,
  output logic                              slave_req_o,
  input  logic                              slave_gnt_i,
  input  logic                              slave_rvalid_i,
  output logic                              slave_we_o,
  output logic [OBI_BEW-1:0]                slave_be_o,
  output logic [OBI_AW-1:0]                 slave_addr_o,
  output logic [OBI_DW-1:0]                 slave_wdata_o,
  input  logic [OBI_DW-1:0]                 slave_rdata_i,
  output logic [OCNT_W-1:0]                 outstanding_o,
  output logic                              err_o
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             err_q, err_d;

  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  obi_req_t         sel_req;
  obi_rsp_t         slave_rsp;

  logic             fifo_full, fifo_empty;
  logic [IDX_W-1:0] fifo_head;
  logic             accept;
  logic             resp_ok;

  // Pick the locked master while it still requests, else the first requester from rr_ptr upward.
  always_comb begin
    int unsigned cand;
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    if (lock_q && master_req_i[lock_idx_q]) begin
      sel_valid = 1'b1;
      sel_idx   = lock_idx_q;
    end else begin
      for (int unsigned i = 0; i < MASTERS; i++) begin
        cand = 32'(rr_ptr_q) + i;
        if (cand >= MASTERS) cand = cand - MASTERS;
        if (!sel_valid && master_req_i[cand]) begin
          sel_valid = 1'b1;
          sel_idx   = IDX_W'(cand);
        end
      end
    end
  end

  // Route the selected master's attributes to the slave; zero when idle.
  always_comb begin
    sel_req = '0;
    if (sel_valid) begin
      sel_req.we    = master_we_i[sel_idx];
      sel_req.be    = master_be_i[sel_idx];
      sel_req.addr  = master_addr_i[sel_idx];
      sel_req.wdata = master_wdata_i[sel_idx];
    end
  end

  assign slave_we_o    = sel_req.we;
  assign slave_be_o    = sel_req.be;
  assign slave_addr_o  = sel_req.addr;
  assign slave_wdata_o = sel_req.wdata;

  // A full routing FIFO blocks new requests so every response always has a destination.
  assign slave_req_o = sel_valid & ~fifo_full;
  assign accept      = slave_req_o & slave_gnt_i;
  assign resp_ok     = slave_rvalid_i & ~fifo_empty;

  // Zero-latency grant pass-through to the selected master.
  always_comb begin
    master_gnt_o = '0;
    if (accept) master_gnt_o[sel_idx] = 1'b1;
  end

  // Response valid goes to the master at the FIFO head; rdata is broadcast.
  always_comb begin
    master_rvalid_o = '0;
    if (resp_ok) master_rvalid_o[fifo_head] = 1'b1;
  end

  assign slave_rsp.rdata = slave_rdata_i;

  // Broadcast read data to every master port.
  always_comb begin
    for (int unsigned m = 0; m < MASTERS; m++) begin
      master_rdata_o[m] = slave_rsp.rdata;
    end
  end

  // Next-state: advance rr_ptr past the accepted master, hold the lock while the slave stalls.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    err_d      = err_q | (slave_rvalid_i & fifo_empty);
    if (accept) begin
      rr_ptr_d = IDX_W'(wrap_inc(32'(sel_idx), MASTERS));
      lock_d   = 1'b0;
    end else if (slave_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel_idx;
    end else if (!sel_valid) begin
      lock_d = 1'b0;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .id_i    (sel_idx),
    .pop_i   (slave_rvalid_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_obi_slave_arbiter.sv
// tb/tb_obi_slave_arbiter.sv - directed scoreboard bench for obi_slave_arbiter
module tb_obi_slave_arbiter;

  localparam int M = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [M-1:0]        m_req, m_gnt, m_rvalid, m_we;
  logic [M-1:0][3:0]   m_be;
  logic [M-1:0][31:0]  m_addr, m_wdata, m_rdata;
  logic                s_req, s_gnt, s_rvalid, s_we;
  logic [3:0]          s_be;
  logic [31:0]         s_addr, s_wdata, s_rdata;
  logic [1:0]          outstanding;
  logic                err;

  int checks = 0;
  int fails  = 0;
  int exp_q[$];
  int rr_model = 0;

  obi_slave_arbiter dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .master_req_i    (m_req),
    .master_gnt_o    (m_gnt),
    .master_rvalid_o (m_rvalid),
    .master_we_i     (m_we),
    .master_be_i     (m_be),
    .master_addr_i   (m_addr),
    .master_wdata_i  (m_wdata),
    .master_rdata_o  (m_rdata),
    .slave_req_o     (s_req),
    .slave_gnt_i     (s_gnt),
    .slave_rvalid_i  (s_rvalid),
    .slave_we_o      (s_we),
    .slave_be_o      (s_be),
    .slave_addr_o    (s_addr),
    .slave_wdata_o   (s_wdata),
    .slave_rdata_i   (s_rdata),
    .outstanding_o   (outstanding),
    .err_o           (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_sel(input logic [M-1:0] req, input int rr);
    for (int i = 0; i < M; i++) begin
      if (req[(rr + i) % M]) return (rr + i) % M;
    end
    return -1;
  endfunction

  // Drive one cycle of stimulus at the falling edge and check the routed response.
  task automatic step(input logic [M-1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
    int m;
    @(negedge clk);
    m_req    = req;
    s_gnt    = gnt;
    s_rvalid = rv;
    s_rdata  = rdata;
    #2;
    if (rv && exp_q.size() > 0) begin
      m = exp_q.pop_front();
      chk("rvalid_route", {29'd0, m_rvalid}, 32'(1 << m));
      chk("rdata_bcast", m_rdata[m], rdata);
    end else begin
      chk("rvalid_none", {29'd0, m_rvalid}, 32'd0);
    end
  endtask

  task automatic expect_accept(input int m);
    chk("gnt", {29'd0, m_gnt}, 32'(1 << m));
    chk("slave_addr", s_addr, m_addr[m]);
    exp_q.push_back(m);
    rr_model = (m + 1) % M;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    m_req    = '0;
    s_gnt    = 1'b0;
    s_rvalid = 1'b0;
    exp_q.delete();
    rr_model = 0;
    #2;
    chk("rst_outstanding", {30'd0, outstanding}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_gnt", {29'd0, m_gnt}, 32'd0);
    chk("rst_rvalid", {29'd0, m_rvalid}, 32'd0);
    chk("rst_slave_req", {31'd0, s_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int m;
    rst_n    = 1'b0;
    m_req    = '0;
    s_gnt    = 1'b0;
    s_rvalid = 1'b0;
    s_rdata  = '0;
    for (int i = 0; i < M; i++) begin
      m_addr[i]  = 32'h1000_0000 + 32'(i * 16);
      m_wdata[i] = 32'hA000_0000 + 32'(i);
      m_be[i]    = 4'hF;
      m_we[i]    = (i == 2);
    end
    repeat (2) @(posedge clk);
    do_reset();

    // Single master read by CoreD.
    step(3'b010, 1'b1, 1'b0, 32'h0);
    chk("t1_slave_we", {31'd0, s_we}, 32'd0);
    expect_accept(1);
    step(3'b000, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("t1_outstanding_1", {30'd0, outstanding}, 32'd1);
    chk("t1_no_gnt", {29'd0, m_gnt}, 32'd0);
    step(3'b000, 1'b0, 1'b0, 32'h0);
    chk("t1_outstanding_0", {30'd0, outstanding}, 32'd0);

    // Round robin from a fresh rr_ptr, with push and pop in the same cycle.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(3'b111, 1'b1, (k > 0), $urandom);
      if (k > 0) chk("rr_outstanding", {30'd0, outstanding}, 32'd1);
      m = exp_sel(3'b111, rr_model);
      chk("rr_order", 32'(m), 32'(k % M));
      expect_accept(m);
    end
    step(3'b000, 1'b0, 1'b1, $urandom);
    step(3'b000, 1'b0, 1'b0, 32'h0);
    chk("rr_drained", {30'd0, outstanding}, 32'd0);

    // Lock holds master 2 while the slave stalls and master 0 arrives.
    step(3'b100, 1'b0, 1'b0, 32'h0);
    chk("lk_req", {31'd0, s_req}, 32'd1);
    chk("lk_addr0", s_addr, m_addr[2]);
    chk("lk_we", {31'd0, s_we}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      step(3'b101, 1'b0, 1'b0, 32'h0);
      chk("lk_addr_hold", s_addr, m_addr[2]);
      chk("lk_wdata_hold", s_wdata, m_wdata[2]);
      chk("lk_no_gnt", {29'd0, m_gnt}, 32'd0);
    end
    step(3'b101, 1'b1, 1'b0, 32'h0);
    expect_accept(2);
    step(3'b001, 1'b1, 1'b0, 32'h0);
    expect_accept(0);

    // Full FIFO blocks the third request until a response frees a slot.
    step(3'b010, 1'b1, 1'b0, 32'h0);
    chk("full_req", {31'd0, s_req}, 32'd0);
    chk("full_gnt", {29'd0, m_gnt}, 32'd0);
    chk("full_outstanding", {30'd0, outstanding}, 32'd2);
    step(3'b010, 1'b1, 1'b1, 32'h1234_5678);
    chk("full_req_pop", {31'd0, s_req}, 32'd0);
    step(3'b010, 1'b1, 1'b0, 32'h0);
    chk("full_resume_outstanding", {30'd0, outstanding}, 32'd1);
    expect_accept(1);
    step(3'b000, 1'b0, 1'b1, 32'h0BAD_F00D);
    step(3'b000, 1'b0, 1'b1, 32'hCAFE_0001);
    step(3'b000, 1'b0, 1'b0, 32'h0);
    chk("full_drained", {30'd0, outstanding}, 32'd0);
    chk("err_clear", {31'd0, err}, 32'd0);

    // Spurious response with nothing outstanding.
    step(3'b000, 1'b0, 1'b1, 32'h5555_AAAA);
    step(3'b000, 1'b0, 1'b0, 32'h0);
    chk("err_set", {31'd0, err}, 32'd1);
    step(3'b000, 1'b0, 1'b0, 32'h0);
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("err_outstanding", {30'd0, outstanding}, 32'd0);

    // Reset in the middle of a burst clears tracking immediately.
    step(3'b001, 1'b1, 1'b0, 32'h0);
    expect_accept(exp_sel(3'b001, rr_model));
    step(3'b010, 1'b1, 1'b0, 32'h0);
    expect_accept(exp_sel(3'b010, rr_model));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outstanding", {30'd0, outstanding}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    m_req    = '0;
    s_gnt    = 1'b0;
    s_rvalid = 1'b0;
    exp_q.delete();
    rr_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b111, 1'b1, 1'b0, 32'h0);
    expect_accept(0);
    step(3'b000, 1'b0, 1'b1, 32'h7777_0000);
    step(3'b000, 1'b0, 1'b0, 32'h0);
    chk("final_outstanding", {30'd0, outstanding}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
